// File: rtl/rv32_pipe_pkg.sv
// Shared RV32 pipeline types: NOP encoding, pc/instr words and the buffered entry payload.
package rv32_pipe_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;

    typedef logic [XLEN-1:0] pc_t;
    typedef logic [XLEN-1:0] instr_t;

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } pipe_entry_t;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready channel carrying a pc/instruction pair between two pipeline stages.
interface pipe_stage_buf_if #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32
);

    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr;

    modport master (
        output valid,
        output pc,
        output instr,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc,
        input  instr,
        output ready
    );

endinterface

// File: rtl/pipe_fifo_ctrl.sv
// Pointer, occupancy and full/empty control for the in-order pipeline buffer.
module pipe_fifo_ctrl #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        i_flush,
    input  logic                                        i_push_req,
    input  logic                                        i_pop_req,
    output logic                                        o_push,
    output logic                                        o_pop,
    output logic                                        o_in_ready,
    output logic                                        o_out_valid,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] o_wr_ptr,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] o_rd_ptr,
    output logic [$clog2(DEPTH+1)-1:0]                  o_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    logic             w_in_ready;
    logic             w_out_valid;

    // Ready/valid depend only on stored occupancy and flush, never on the far-side handshake
    assign w_in_ready  = (r_count < CNT_W'(DEPTH)) & ~i_flush;
    assign w_out_valid = (r_count != '0) & ~i_flush;
    assign w_push      = i_push_req & w_in_ready;
    assign w_pop       = w_out_valid & i_pop_req;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    generate
        if (DEPTH == 1) begin : g_single
            // One slot: the occupancy bit is the whole state
            assign o_wr_ptr = '0;
            assign o_rd_ptr = '0;
        end else begin : g_ring
            logic [PTR_W-1:0] r_wr_ptr;
            logic [PTR_W-1:0] r_rd_ptr;

            // Power-of-two depth lets the pointers wrap by natural overflow
            always_ff @(posedge clk) begin
                if (reset || i_flush) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    end
                end
            end

            assign o_wr_ptr = r_wr_ptr;
            assign o_rd_ptr = r_rd_ptr;
        end
    endgenerate

    assign o_push      = w_push;
    assign o_pop       = w_pop;
    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_count     = r_count;

endmodule

// File: rtl/pipe_stage_buf.sv
// DEPTH-entry in-order pipeline boundary buffer with valid/ready on both sides; NOP bubble when empty.
// Optional PIPE_STAGE_PERF_EN adds saturating stall_cycles / flush_events counters.
module pipe_stage_buf
    import rv32_pipe_pkg::*;
#(
    parameter int unsigned       PC_W     = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(RV32_NOP)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    pipe_stage_buf_if.slave            up,
    pipe_stage_buf_if.master           dn,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                flush_events
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             w_push;
    logic             w_pop;
    logic             w_in_ready;
    logic             w_out_valid;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;

    logic [PC_W-1:0]   r_pc_mem    [DEPTH];
    logic [DATA_W-1:0] r_instr_mem [DEPTH];

    pipe_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (flush),
        .i_push_req  (up.valid),
        .i_pop_req   (dn.ready),
        .o_push      (w_push),
        .o_pop       (w_pop),
        .o_in_ready  (w_in_ready),
        .o_out_valid (w_out_valid),
        .o_wr_ptr    (w_wr_ptr),
        .o_rd_ptr    (w_rd_ptr),
        .o_count     (count)
    );

    // Storage is not reset; contents are only observed behind out_valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[w_wr_ptr]    <= up.pc;
            r_instr_mem[w_wr_ptr] <= up.instr;
        end
    end

    assign up.ready = w_in_ready;
    assign dn.valid = w_out_valid;
    assign dn.pc    = w_out_valid ? r_pc_mem[w_rd_ptr]    : '0;
    assign dn.instr = w_out_valid ? r_instr_mem[w_rd_ptr] : NOP_WORD;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    // Saturating counters; only reset clears them
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (up.valid && !w_in_ready && !flush && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (flush && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

    logic w_unused;
    assign w_unused = w_pop;

endmodule
